// File: rtl/zbin_vertex_select.sv
// Primary-vertex z-bin selector: aggregates per-bin L1/L2 done flags, scans HT for the best bin,
// and serves jet readout from it. Optional build macro ZBIN_HT_THRESH_EN adds an HT acceptance threshold.
module zbin_vertex_select #(
    parameter int NZ     = 8,
    parameter int SEL_W  = 4,
    parameter int HT_W   = 9,
    parameter int NUM_W  = 8,
    parameter int JET_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   start,
    input  logic                   event_done,
    input  logic [NZ-1:0]          l1_done_in,
    input  logic [NZ-1:0]          l2_done_in,
    input  logic [NZ*HT_W-1:0]     ht_in,
    input  logic [NZ*NUM_W-1:0]    num_in,
    input  logic [NZ*JET_W-1:0]    jet_in,
`ifdef ZBIN_HT_THRESH_EN
    input  logic [HT_W-1:0]        ht_thresh,
`endif
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [ADDR_W-1:0]      jet_addr_out,
    output logic [JET_W-1:0]       jet_out,
    output logic                   jet_valid,
    output logic [HT_W-1:0]        ht_max,
    output logic [NUM_W-1:0]       n_max,
    output logic [SEL_W-1:0]       zmax,
    output logic                   L1done,
    output logic                   all_done
);

    localparam int NSEL  = 2 ** SEL_W;
    localparam int CMP_W = (ADDR_W > NUM_W) ? ADDR_W : NUM_W;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_WAIT, S_L2_WAIT, S_SCAN, S_READY
    } state_t;

    state_t            state_q;
    logic [NZ-1:0]     sticky_q;
    logic [SEL_W-1:0]  idx_q;
    logic [HT_W-1:0]   best_ht_q;
    logic [SEL_W-1:0]  best_sel_q;
    logic [HT_W-1:0]   ht_max_q;
    logic [NUM_W-1:0]  n_max_q;
    logic [SEL_W-1:0]  zmax_q;
    logic              l1done_q;
    logic              all_done_q;

    logic [ADDR_W-1:0] jet_addr_q;
    logic              s1_q;
    logic              s2_q;
    logic              jet_valid_q;
    logic [JET_W-1:0]  jet_out_q;

    // Unused selector codes map to zero so every index is in range.
    logic [HT_W-1:0]   ht_a  [NSEL];
    logic [NUM_W-1:0]  num_a [NSEL];
    logic [JET_W-1:0]  jet_a [NSEL];

    for (genvar k = 0; k < NSEL; k++) begin : g_unpack
        if (k < NZ) begin : g_bin
            assign ht_a[k]  = ht_in[k*HT_W +: HT_W];
            assign num_a[k] = num_in[k*NUM_W +: NUM_W];
            assign jet_a[k] = jet_in[k*JET_W +: JET_W];
        end else begin : g_pad
            assign ht_a[k]  = '0;
            assign num_a[k] = '0;
            assign jet_a[k] = '0;
        end
    end

    logic [HT_W-1:0]  ht_cur;
    logic             gt;
    logic [HT_W-1:0]  best_ht_d;
    logic [SEL_W-1:0] best_sel_d;
    logic [NZ-1:0]    sticky_d;
    logic             scan_last;
    logic             below;
    logic             rd_ok;

    assign ht_cur     = ht_a[idx_q];
    assign gt         = ht_cur > best_ht_q;
    assign best_ht_d  = gt ? ht_cur : best_ht_q;
    assign best_sel_d = gt ? idx_q : best_sel_q;
    assign sticky_d   = sticky_q | l2_done_in;
    assign scan_last  = (idx_q == SEL_W'(NZ - 1));
`ifdef ZBIN_HT_THRESH_EN
    assign below      = best_ht_d < ht_thresh;
`else
    assign below      = 1'b0;
`endif
    assign rd_ok      = rd_en && (state_q == S_READY) &&
                        (CMP_W'(rd_addr) < CMP_W'(n_max_q));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_IDLE;
            sticky_q   <= '0;
            idx_q      <= '0;
            best_ht_q  <= '0;
            best_sel_q <= '0;
            ht_max_q   <= '0;
            n_max_q    <= '0;
            zmax_q     <= '0;
            l1done_q   <= 1'b1;
            all_done_q <= 1'b0;
        end else if (start) begin
            // A new event always wins, including over a pending event_done or a running scan.
            state_q    <= S_L1_WAIT;
            l1done_q   <= 1'b0;
            all_done_q <= 1'b0;
            sticky_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_L1_WAIT: begin
                    if (&l1_done_in) begin
                        l1done_q <= 1'b1;
                        state_q  <= S_L2_WAIT;
                    end
                end
                S_L2_WAIT: begin
                    sticky_q <= sticky_d;
                    if (&sticky_d) begin
                        idx_q      <= '0;
                        best_ht_q  <= '0;
                        best_sel_q <= '0;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_ht_q  <= best_ht_d;
                    best_sel_q <= best_sel_d;
                    idx_q      <= idx_q + 1'b1;
                    if (scan_last) begin
                        ht_max_q   <= best_ht_d;
                        n_max_q    <= below ? '0 : num_a[best_sel_d];
                        zmax_q     <= below ? '0 : best_sel_d;
                        all_done_q <= 1'b1;
                        state_q    <= S_READY;
                    end
                end
                S_READY: begin
                    if (event_done) begin
                        all_done_q <= 1'b0;
                        sticky_q   <= '0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stage 1 registers the address broadcast; the bins answer one cycle later, captured in stage 3.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            jet_addr_q  <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            jet_valid_q <= 1'b0;
            jet_out_q   <= '0;
        end else begin
            jet_addr_q  <= rd_addr;
            s1_q        <= rd_ok;
            s2_q        <= s1_q;
            jet_valid_q <= s2_q;
            jet_out_q   <= s2_q ? jet_a[zmax_q] : '0;
        end
    end

    assign jet_addr_out = jet_addr_q;
    assign jet_out      = jet_out_q;
    assign jet_valid    = jet_valid_q;
    assign ht_max       = ht_max_q;
    assign n_max        = n_max_q;
    assign zmax         = zmax_q;
    assign L1done       = l1done_q;
    assign all_done     = all_done_q;

endmodule

// File: tb/tb_zbin_vertex_select.sv
// Bench for zbin_vertex_select: event-level model of selection plus a readout scoreboard, checked every cycle.
module tb_zbin_vertex_select;

    localparam int NZ = 8;

    logic              clk = 1'b0;
    logic              rstb;
    logic              start, event_done, rd_en;
    logic [NZ-1:0]     l1_done_in, l2_done_in;
    logic [NZ*9-1:0]   ht_in;
    logic [NZ*8-1:0]   num_in;
    logic [NZ*32-1:0]  jet_in;
    logic [8:0]        ht_thresh;
    logic [7:0]        rd_addr;
    logic [7:0]        jet_addr_out;
    logic [31:0]       jet_out;
    logic              jet_valid;
    logic [8:0]        ht_max;
    logic [7:0]        n_max;
    logic [3:0]        zmax;
    logic              L1done, all_done;

    always #5 clk = ~clk;

    zbin_vertex_select dut (
        .clk(clk), .rstb(rstb), .start(start), .event_done(event_done),
        .l1_done_in(l1_done_in), .l2_done_in(l2_done_in),
        .ht_in(ht_in), .num_in(num_in), .jet_in(jet_in),
`ifdef ZBIN_HT_THRESH_EN
        .ht_thresh(ht_thresh),
`endif
        .rd_en(rd_en), .rd_addr(rd_addr), .jet_addr_out(jet_addr_out),
        .jet_out(jet_out), .jet_valid(jet_valid), .ht_max(ht_max),
        .n_max(n_max), .zmax(zmax), .L1done(L1done), .all_done(all_done)
    );

    function automatic logic [31:0] jw(int b, int a);
        return 32'hA000_0000 | (32'(b) << 16) | 32'(a);
    endfunction

    // Per-bin BRAM: word returned one cycle after the address broadcast.
    always @(posedge clk)
        for (int b = 0; b < NZ; b++)
            jet_in[b*32 +: 32] <= jw(b, int'(jet_addr_out));

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic        exp_l1done, exp_all_done, exp_jv;
    logic [8:0]  exp_ht_max;
    logic [7:0]  exp_n_max;
    logic [3:0]  exp_zmax;
    logic [31:0] exp_jo;
    bit          pv_q[$];
    logic [31:0] pw_q[$];

    int mht[NZ];
    int mnum[NZ];
    int l2c[NZ];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("L1done",    32'(L1done),    32'(exp_l1done));
            check("all_done",  32'(all_done),  32'(exp_all_done));
            check("ht_max",    32'(ht_max),    32'(exp_ht_max));
            check("n_max",     32'(n_max),     32'(exp_n_max));
            check("zmax",      32'(zmax),      32'(exp_zmax));
            check("jet_valid", 32'(jet_valid), 32'(exp_jv));
            check("jet_out",   jet_out,        exp_jo);
        end
    end

    // Requests are judged against the outputs visible when they are issued; results appear two edges later.
    task automatic step();
        bit v;
        logic [31:0] w;
        v = rd_en && exp_all_done && (rd_addr < exp_n_max);
        w = v ? jw(int'(exp_zmax), int'(rd_addr)) : 32'h0;
        pv_q.push_back(v);
        pw_q.push_back(w);
        @(posedge clk); #1;
        exp_jv = pv_q.pop_front();
        exp_jo = pw_q.pop_front();
    endtask

    task automatic model_reset();
        exp_l1done = 1'b1; exp_all_done = 1'b0; exp_jv = 1'b0; exp_jo = '0;
        exp_ht_max = '0; exp_n_max = '0; exp_zmax = '0;
        pv_q.delete(); pw_q.delete();
        repeat (2) begin pv_q.push_back(1'b0); pw_q.push_back(32'h0); end
    endtask

    task automatic apply_bins();
        for (int k = 0; k < NZ; k++) begin
            ht_in[k*9 +: 9]  = 9'(mht[k]);
            num_in[k*8 +: 8] = 8'(mnum[k]);
        end
    endtask

    task automatic run_event(input int abort_at);
        int maxc, best, sel;
        start = 1'b1; l1_done_in = '0; l2_done_in = '0;
        apply_bins();
        step();
        start = 1'b0; exp_l1done = 1'b0; exp_all_done = 1'b0;
        l1_done_in = 8'h0F; step();
        l1_done_in = 8'hFF; step();
        exp_l1done = 1'b1;
        maxc = 0;
        for (int k = 0; k < NZ; k++) if (l2c[k] > maxc) maxc = l2c[k];
        for (int c = 0; c <= maxc; c++) begin
            for (int k = 0; k < NZ; k++) l2_done_in[k] = (l2c[k] == c);
            step();
        end
        l2_done_in = '0;
        for (int k = 1; k <= NZ; k++) begin
            if (k == abort_at) begin
                start = 1'b1; l1_done_in = '0;
                step();
                start = 1'b0; exp_l1done = 1'b0;
                return;
            end
            step();
        end
        best = 0; sel = 0;
        for (int k = 0; k < NZ; k++) if (mht[k] > best) begin best = mht[k]; sel = k; end
        exp_all_done = 1'b1;
        exp_ht_max   = 9'(best);
        if (best < int'(ht_thresh)) begin
            exp_n_max = '0; exp_zmax = '0;
        end else begin
            exp_n_max = 8'(mnum[sel]); exp_zmax = 4'(sel);
        end
    endtask

    task automatic end_event();
        event_done = 1'b1; step();
        event_done = 1'b0; exp_all_done = 1'b0;
    endtask

    task automatic read_burst(input int n, output int nv, output logic [31:0] fw);
        nv = 0; fw = '0;
        for (int a = 0; a < n + 3; a++) begin
            rd_en = (a < n); rd_addr = 8'(a);
            step();
            if (jet_valid === 1'b1) begin
                if (nv == 0) fw = jet_out;
                nv++;
            end
        end
        rd_en = 1'b0;
    endtask

    int nv;
    logic [31:0] fw;

    initial begin
        rstb = 1'b0; start = 1'b0; event_done = 1'b0; rd_en = 1'b0; rd_addr = '0;
        l1_done_in = '0; l2_done_in = '0; ht_in = '0; num_in = '0; ht_thresh = '0;
        model_reset();
        #23;
        check("rst_L1done",   32'(L1done),    32'd1);
        check("rst_all_done", 32'(all_done),  32'd0);
        check("rst_jet_valid",32'(jet_valid), 32'd0);
        check("rst_zmax",     32'(zmax),      32'd0);
        @(posedge clk); #1; rstb = 1'b1; chk_en = 1'b1;

        // 1: simultaneous L2, tie between bins 1 and 3
        mht  = '{5, 40, 12, 40, 3, 0, 7, 9};
        mnum = '{10, 3, 7, 2, 9, 1, 4, 6};
        l2c  = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_event(0);
        check("t1_zmax",   32'(zmax),   32'd1);
        check("t1_ht_max", 32'(ht_max), 32'd40);
        check("t1_n_max",  32'(n_max),  32'd3);
        end_event();

        // 2: staggered single-cycle L2 pulses
        l2c = '{3, 7, 0, 5, 1, 6, 2, 4};
        run_event(0);
        check("t2_zmax",   32'(zmax),   32'd1);
        check("t2_ht_max", 32'(ht_max), 32'd40);

        // 3: reads 0..4 with n_max=3
        read_burst(5, nv, fw);
        check("t3_nvalid", 32'(nv), 32'd3);
        check("t3_word0",  fw,      32'hA001_0000);
        end_event();

        // 4: abort mid-scan, then a clean event
        mht = '{1, 2, 3, 4, 5, 6, 7, 100};
        l2c = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_event(3);
        check("t4_hold_ht",  32'(ht_max),   32'd40);
        check("t4_hold_z",   32'(zmax),     32'd1);
        check("t4_L1done",   32'(L1done),   32'd0);
        check("t4_all_done", 32'(all_done), 32'd0);
        run_event(0);
        check("t4_zmax",  32'(zmax),   32'd7);
        check("t4_ht",    32'(ht_max), 32'd100);
        check("t4_n_max", 32'(n_max),  32'd6);

        // 5: start and event_done together in READY
        start = 1'b1; event_done = 1'b1; l1_done_in = '0; step();
        start = 1'b0; event_done = 1'b0; exp_l1done = 1'b0; exp_all_done = 1'b0;
        check("t5_all_done", 32'(all_done), 32'd0);
        l1_done_in = 8'hFF; step(); exp_l1done = 1'b1;
        check("t5_in_l1wait", 32'(L1done), 32'd1);
        mht = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_event(0);
        check("t5_zero_zmax", 32'(zmax),  32'd0);
        check("t5_zero_n",    32'(n_max), 32'd10);
        rd_en = 1'b1; rd_addr = 8'd0; step();
        rd_addr = 8'd1; step();
        #2 rstb = 1'b0; chk_en = 1'b0;
        #1;
        check("t5_rst_jv",  32'(jet_valid), 32'd0);
        check("t5_rst_L1",  32'(L1done),    32'd1);
        check("t5_rst_all", 32'(all_done),  32'd0);
        check("t5_rst_ht",  32'(ht_max),    32'd0);
        rd_en = 1'b0; l1_done_in = '0;
        @(posedge clk); #1;
        model_reset(); rstb = 1'b1; chk_en = 1'b1;

        // 6: post-reset event; threshold build rejects it
        mht = '{5, 40, 12, 40, 3, 0, 7, 9};
`ifdef ZBIN_HT_THRESH_EN
        ht_thresh = 9'd50;
`endif
        run_event(0);
        read_burst(3, nv, fw);
        check("t6_ht_max", 32'(ht_max), 32'd40);
`ifdef ZBIN_HT_THRESH_EN
        check("t6_n_max",  32'(n_max), 32'd0);
        check("t6_zmax",   32'(zmax),  32'd0);
        check("t6_nvalid", 32'(nv),    32'd0);
`else
        check("t6_n_max",  32'(n_max), 32'd3);
        check("t6_zmax",   32'(zmax),  32'd1);
        check("t6_nvalid", 32'(nv),    32'd3);
`endif
        end_event();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
